// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes, memory waits.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_controller #(
    parameter int REG_ADDR_W = 5,
    parameter int STAT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  stall_idex,
    output logic                  stall_exmem,
    output logic                  clear_ifid,
    output logic                  clear_idex,
    output logic [1:0]            state
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0]     stall_count
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        MEM_WAIT  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic mem_wait;
    logic load_use;

    assign mem_wait = mem_req && !mem_ready;
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        stall_exmem = 1'b0;
        clear_ifid  = 1'b0;
        clear_idex  = 1'b0;
        state_nxt   = RUN;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (mem_wait) begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        stall_idex  = 1'b1;
                        stall_exmem = 1'b1;
                        state_nxt   = MEM_WAIT;
                    end else if (ex_branch_taken) begin
                        // Flush wins; the dependent instruction is squashed anyway.
                        clear_ifid = 1'b1;
                        clear_idex = 1'b1;
                    end else if (load_use) begin
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        clear_idex = 1'b1;
                        state_nxt  = LU_BUBBLE;
                    end
                end
                LU_BUBBLE: begin
                    if (mem_wait) begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        stall_idex  = 1'b1;
                        stall_exmem = 1'b1;
                        state_nxt   = MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_ready) begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        stall_idex  = 1'b1;
                        stall_exmem = 1'b1;
                        state_nxt   = MEM_WAIT;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_nxt;
    end

    assign state = state_q;

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset)                          cnt_q <= '0;
        else if (stall_pc && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end

    assign stall_count = cnt_q;
`endif

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter REG_ADDR_W, default 5, register-address width.
REQ-002 Parameter STAT_W, default 16, stall-statistics counter width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 id_rs1  input  REG_ADDR_W  source register 1 of the instruction in ID.
REQ-006 id_rs2  input  REG_ADDR_W  source register 2 of the instruction in ID.
REQ-007 ex_rd  input  REG_ADDR_W  destination register of the instruction in EX.
REQ-008 ex_mem_read  input  1  instruction in EX is a load.
REQ-009 ex_branch_taken  input  1  branch or jump resolved taken in EX.
REQ-010 mem_req  input  1  instruction in MEM accesses data memory this cycle.
REQ-011 mem_ready  input  1  data memory completes the access this cycle.
REQ-012 stall_pc, stall_ifid, stall_idex, stall_exmem  output  1 each  hold controls for PC, IF/ID, ID/EX and EX/MEM; 1 = register holds its value.
REQ-013 clear_ifid, clear_idex  output  1 each  synchronous clear controls; 1 = register loads zero (bubble).
REQ-014 state  output  2  current FSM state: RUN=0, LU_BUBBLE=1, MEM_WAIT=2.
REQ-015 stall_count  output  STAT_W  stall-cycle count; present only with HAZARD_STATS_EN.

Function
REQ-016 All stall_*/clear_* outputs SHALL be combinational from state and inputs, valid in the same cycle as the hazard.
REQ-017 Load-use hazard SHALL be: ex_mem_read=1, ex_rd!=0, and ex_rd equals id_rs1 or id_rs2.
REQ-018 In RUN, priority SHALL be: memory wait > taken branch > load-use > none.
REQ-019 RUN, mem_req=1 and mem_ready=0: assert all four stall_*, clear_*=0, next state MEM_WAIT.
REQ-020 RUN, ex_branch_taken=1 (no memory wait): assert clear_ifid and clear_idex, stall_*=0, stay in RUN; a simultaneous load-use is discarded.
REQ-021 RUN, load-use only: assert stall_pc, stall_ifid and clear_idex, next state LU_BUBBLE.
REQ-022 LU_BUBBLE: all outputs SHALL be 0 and hazard detection suppressed, except that memory wait (REQ-019) applies; next state RUN, or MEM_WAIT on memory wait.
REQ-023 MEM_WAIT, mem_ready=0: assert all four stall_*, ignore ex_branch_taken and load-use, stay in MEM_WAIT.
REQ-024 MEM_WAIT, mem_ready=1: all stall_* SHALL be 0 in that cycle; next state RUN, and branch/load-use are evaluated from the next cycle.
REQ-025 mem_req=1 with mem_ready=1 in the same cycle SHALL cause no stall.
REQ-026 clear_* and stall_* SHALL never both be asserted for the same register.
REQ-027 State encoding 3 SHALL be unreachable and SHALL return to RUN on the next edge with all outputs 0.

Reset
REQ-028 On a rising edge with reset=1, state SHALL become RUN and stall_count (if present) 0.
REQ-029 While reset=1, all stall_* and clear_* SHALL be 0 regardless of inputs or state.
REQ-030 Reset asserted in MEM_WAIT or LU_BUBBLE SHALL abandon the pending stall; no stall carries over after reset.

Configuration
REQ-031 Macro HAZARD_STATS_EN defined: stall_count SHALL increment by 1 on each edge where stall_pc=1 and reset=0, and saturate at all-ones.
REQ-032 Macro HAZARD_STATS_EN undefined: port stall_count and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 -> stall_pc=stall_ifid=clear_idex=1 for exactly 1 cycle, state 1 then 0.
REQ-034 x0 load: ex_mem_read=1, ex_rd=0, id_rs1=0 -> no stall, no clear, state stays 0.
REQ-035 Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> four stall_* high 3 cycles and low on the ready cycle; with HAZARD_STATS_EN stall_count=3.
REQ-036 Branch plus load-use same cycle: ex_branch_taken=1, load-use on rs1 -> clear_ifid=clear_idex=1, stall_pc=0, state stays 0.
REQ-037 Reset in MEM_WAIT: reset=1 for 1 cycle during wait -> all outputs 0 during reset, state 0 afterwards, stall_count=0.
REQ-038 Saturation: STAT_W=4, 20 stall cycles with HAZARD_STATS_EN -> stall_count=15.
